// File: rtl/mantisa_norm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mantisa_norm_arbiter_if
//  Description : Handshake bundle for the shared mantissa normalizer.
//                Requester side: req_vld / req_rdy / req_mag / req_exp
//                (packed, requester i at slice i).
//                Response side : rsp_vld / rsp_rdy / rsp_mag / rsp_exp /
//                rsp_id / rsp_zero / rsp_unf.
//                master modport : traffic source/sink (drives requests,
//                                 consumes responses)
//                slave modport  : the normalizer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface mantisa_norm_arbiter_if #(
    parameter int REQ_N = 2,
    parameter int WIDTH = 24,
    parameter int EXP_W = 8
);
    localparam int ID_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

    logic [REQ_N-1:0]       req_vld;
    logic [REQ_N-1:0]       req_rdy;
    logic [REQ_N*WIDTH-1:0] req_mag;
    logic [REQ_N*EXP_W-1:0] req_exp;

    logic                   rsp_vld;
    logic                   rsp_rdy;
    logic [WIDTH-1:0]       rsp_mag;
    logic [EXP_W-1:0]       rsp_exp;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_zero;
    logic                   rsp_unf;

    modport master (
        output req_vld, req_mag, req_exp, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_mag, rsp_exp, rsp_id, rsp_zero, rsp_unf
    );

    modport slave (
        input  req_vld, req_mag, req_exp, rsp_rdy,
        output req_rdy, rsp_vld, rsp_mag, rsp_exp, rsp_id, rsp_zero, rsp_unf
    );
endinterface
`default_nettype wire

// File: rtl/mantisa_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mantisa_norm_arbiter
//  Description : Round-robin arbiter in front of one shared leading-one
//                detector + normalizing shifter. Two register stages:
//                S1 captures the granted request, S2 holds the normalized
//                result and drives the response outputs.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous active-low reset
//                bus    - mantisa_norm_arbiter_if.slave (request and
//                         response handshakes)
//                stat_zero_cnt / stat_unf_cnt - saturating event counters,
//                         present only when MANTISA_NORM_STATS_EN is defined
//  Options     : `define MANTISA_NORM_STATS_EN to add the statistics counters
//  Revision    : 1.0 - initial release
// ============================================================================
module mantisa_norm_arbiter #(
    parameter int REQ_N = 2,
    parameter int WIDTH = 24,
    parameter int EXP_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mantisa_norm_arbiter_if.slave  bus
`ifdef MANTISA_NORM_STATS_EN
    ,
    output logic [31:0]            stat_zero_cnt,
    output logic [31:0]            stat_unf_cnt
`endif
);

    localparam int ID_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  ptr_q,     ptr_d;
    logic             s1_vld_q,  s1_vld_d;
    logic [WIDTH-1:0] s1_mag_q,  s1_mag_d;
    logic [EXP_W-1:0] s1_exp_q,  s1_exp_d;
    logic [ID_W-1:0]  s1_id_q,   s1_id_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [WIDTH-1:0] rsp_mag_q, rsp_mag_d;
    logic [EXP_W-1:0] rsp_exp_q, rsp_exp_d;
    logic [ID_W-1:0]  rsp_id_q,  rsp_id_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_unf_q,  rsp_unf_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic            w_found;
    logic [ID_W-1:0] w_grant;
    logic [ID_W-1:0] w_ptr_nxt;
    logic            w_s2_load;
    logic            w_s1_accept;
    logic            w_xfer;

    // (base + off) mod REQ_N without a divider; off is always < REQ_N
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= REQ_N) s = s - REQ_N;
        return ID_W'(s);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < REQ_N; k++) begin
            if (!w_found && bus.req_vld[wrap_idx(ptr_q, k)]) begin
                w_found = 1'b1;
                w_grant = wrap_idx(ptr_q, k);
            end
        end
    end

    assign w_ptr_nxt   = (int'(w_grant) == REQ_N - 1) ? '0 : w_grant + ID_W'(1);
    assign w_s2_load   = s1_vld_q & (~rsp_vld_q | bus.rsp_rdy);
    assign w_s1_accept = ~s1_vld_q | w_s2_load;
    // rst_n gates the grant so nothing is handshaken while reset is held
    assign w_xfer      = rst_n & w_found & w_s1_accept;

    always_comb begin
        bus.req_rdy = '0;
        if (w_xfer) bus.req_rdy[w_grant] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Stage 1 next state
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d    = ptr_q;
        s1_vld_d = s1_vld_q;
        s1_mag_d = s1_mag_q;
        s1_exp_d = s1_exp_q;
        s1_id_d  = s1_id_q;
        if (w_xfer) begin
            ptr_d    = w_ptr_nxt;
            s1_vld_d = 1'b1;
            s1_mag_d = bus.req_mag[int'(w_grant)*WIDTH +: WIDTH];
            s1_exp_d = bus.req_exp[int'(w_grant)*EXP_W +: EXP_W];
            s1_id_d  = w_grant;
        end else if (w_s2_load) begin
            s1_vld_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Normalization (leading-one detect + shift), S1 -> S2
    // ------------------------------------------------------------------
    logic [31:0] w_p;
    logic        w_nz;
    logic [31:0] w_sh;
    logic [31:0] w_exp_ext;

    always_comb begin
        w_p  = '0;
        w_nz = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s1_mag_q[i]) begin
                w_p  = 32'(i);
                w_nz = 1'b1;
            end
        end
    end

    assign w_sh      = 32'(WIDTH - 1) - w_p;
    assign w_exp_ext = 32'(s1_exp_q);

    always_comb begin
        rsp_vld_d  = rsp_vld_q;
        rsp_mag_d  = rsp_mag_q;
        rsp_exp_d  = rsp_exp_q;
        rsp_id_d   = rsp_id_q;
        rsp_zero_d = rsp_zero_q;
        rsp_unf_d  = rsp_unf_q;
        if (w_s2_load) begin
            rsp_vld_d = 1'b1;
            rsp_id_d  = s1_id_q;
            if (!w_nz) begin
                rsp_mag_d  = '0;
                rsp_exp_d  = '0;
                rsp_zero_d = 1'b1;
                rsp_unf_d  = 1'b0;
            end else if (w_sh <= w_exp_ext) begin
                // sh == exp lands exactly on exponent 0 and is still normal
                rsp_mag_d  = s1_mag_q << w_sh;
                rsp_exp_d  = s1_exp_q - EXP_W'(w_sh);
                rsp_zero_d = 1'b0;
                rsp_unf_d  = 1'b0;
            end else begin
                // exponent runs out first: shift only as far as it allows
                rsp_mag_d  = s1_mag_q << s1_exp_q;
                rsp_exp_d  = '0;
                rsp_zero_d = 1'b0;
                rsp_unf_d  = 1'b1;
            end
        end else if (bus.rsp_rdy) begin
            rsp_vld_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_mag_q   <= '0;
            s1_exp_q   <= '0;
            s1_id_q    <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_mag_q  <= '0;
            rsp_exp_q  <= '0;
            rsp_id_q   <= '0;
            rsp_zero_q <= 1'b0;
            rsp_unf_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            s1_vld_q   <= s1_vld_d;
            s1_mag_q   <= s1_mag_d;
            s1_exp_q   <= s1_exp_d;
            s1_id_q    <= s1_id_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_mag_q  <= rsp_mag_d;
            rsp_exp_q  <= rsp_exp_d;
            rsp_id_q   <= rsp_id_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_unf_q  <= rsp_unf_d;
        end
    end

    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_mag  = rsp_mag_q;
    assign bus.rsp_exp  = rsp_exp_q;
    assign bus.rsp_id   = rsp_id_q;
    assign bus.rsp_zero = rsp_zero_q;
    assign bus.rsp_unf  = rsp_unf_q;

`ifdef MANTISA_NORM_STATS_EN
    // ------------------------------------------------------------------
    // Saturating counters of zero / underflow results actually consumed
    // ------------------------------------------------------------------
    logic [31:0] zero_cnt_q, zero_cnt_d;
    logic [31:0] unf_cnt_q,  unf_cnt_d;
    logic        w_rsp_hs;

    assign w_rsp_hs = rsp_vld_q & bus.rsp_rdy;

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        unf_cnt_d  = unf_cnt_q;
        if (w_rsp_hs && rsp_zero_q && (zero_cnt_q != 32'hFFFF_FFFF))
            zero_cnt_d = zero_cnt_q + 32'd1;
        if (w_rsp_hs && rsp_unf_q && (unf_cnt_q != 32'hFFFF_FFFF))
            unf_cnt_d = unf_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_cnt_q <= '0;
            unf_cnt_q  <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
            unf_cnt_q  <= unf_cnt_d;
        end
    end

    assign stat_zero_cnt = zero_cnt_q;
    assign stat_unf_cnt  = unf_cnt_q;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_mantisa_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mantisa_norm_arbiter
//  Description : Scoreboard bench for mantisa_norm_arbiter. Directed vectors
//                carry hand-computed expected responses, queued in expected
//                output order; a negedge monitor compares every presented
//                response (and the held value during stalls).
//                Also builds with MANTISA_NORM_STATS_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mantisa_norm_arbiter;

    localparam int REQ_N = 2;
    localparam int WIDTH = 24;
    localparam int EXP_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mantisa_norm_arbiter_if #(.REQ_N(REQ_N), .WIDTH(WIDTH), .EXP_W(EXP_W)) bus ();

`ifdef MANTISA_NORM_STATS_EN
    logic [31:0] stat_zero_cnt;
    logic [31:0] stat_unf_cnt;
`endif

    mantisa_norm_arbiter #(.REQ_N(REQ_N), .WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus)
`ifdef MANTISA_NORM_STATS_EN
        ,
        .stat_zero_cnt (stat_zero_cnt),
        .stat_unf_cnt  (stat_unf_cnt)
`endif
    );

    typedef struct {
        logic [23:0] mag;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [23:0] mag;
        logic [7:0]  exp;
        logic        id;
        logic        zero;
        logic        unf;
    } exp_t;

    vec_t lane_q[2][$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One directed vector: request on a lane plus its expected response.
    // Call order defines the expected response order.
    task automatic item(input int lane, input logic [23:0] mag, input logic [7:0] exp,
                        input logic [23:0] emag, input logic [7:0] eexp,
                        input logic zero, input logic unf);
        vec_t v;
        exp_t e;
        v.mag = mag;  v.exp = exp;
        e.mag = emag; e.exp = eexp; e.id = 1'(lane); e.zero = zero; e.unf = unf;
        lane_q[lane].push_back(v);
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while ((lane_q[0].size() + lane_q[1].size() + sb.size()) != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_chk++;
        if ((lane_q[0].size() + lane_q[1].size() + sb.size()) != 0) begin
            n_fail++;
            $display("FAIL %s: timeout, %0d items left, required 0", name,
                     lane_q[0].size() + lane_q[1].size() + sb.size());
        end
    endtask

    // Request driver: presents the head of each lane queue
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (lane_q[i].size() > 0) begin
                bus.req_vld[i]                 = 1'b1;
                bus.req_mag[i*WIDTH +: WIDTH]  = lane_q[i][0].mag;
                bus.req_exp[i*EXP_W +: EXP_W]  = lane_q[i][0].exp;
            end else begin
                bus.req_vld[i]                 = 1'b0;
                bus.req_mag[i*WIDTH +: WIDTH]  = '0;
                bus.req_exp[i*EXP_W +: EXP_W]  = '0;
            end
        end
    end

    // Acceptor + response monitor (inputs are stable at negedge)
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.req_vld[i] && bus.req_rdy[i] && lane_q[i].size() > 0)
                    void'(lane_q[i].pop_front());
            end
            if (bus.rsp_vld) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got mag=0x%0h id=%0d, required no response",
                             bus.rsp_mag, bus.rsp_id);
                end else begin
                    chk("rsp_mag",  64'(bus.rsp_mag),  64'(sb[0].mag));
                    chk("rsp_exp",  64'(bus.rsp_exp),  64'(sb[0].exp));
                    chk("rsp_id",   64'(bus.rsp_id),   64'(sb[0].id));
                    chk("rsp_zero", 64'(bus.rsp_zero), 64'(sb[0].zero));
                    chk("rsp_unf",  64'(bus.rsp_unf),  64'(sb[0].unf));
                    if (bus.rsp_rdy) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n       = 1'b0;
        bus.rsp_rdy = 1'b1;

        // ---------------- reset with both requesters valid ----------------
        item(0, 24'h000100, 8'd100, 24'h800000, 8'd85, 1'b0, 1'b0);
        item(1, 24'h400000, 8'd7,   24'h800000, 8'd6,  1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
        chk("rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
        chk("rst_rsp_fields", {bus.rsp_mag, bus.rsp_exp, bus.rsp_id, bus.rsp_zero, bus.rsp_unf}, 64'd0);
`ifdef MANTISA_NORM_STATS_EN
        chk("rst_stat_zero", 64'(stat_zero_cnt), 64'd0);
        chk("rst_stat_unf",  64'(stat_unf_cnt),  64'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant", 64'(bus.req_rdy), 64'b01);
        @(negedge clk);
        chk("latency_s1", 64'(bus.rsp_vld), 64'd0);
        @(negedge clk);
        chk("latency_s2", 64'(bus.rsp_vld), 64'd1);
        drain("drain_single", 30);

        // ---------------- corner values ----------------
        item(0, 24'h000000, 8'd50,  24'h000000, 8'd0,   1'b1, 1'b0);
        item(0, 24'h000001, 8'd10,  24'h000400, 8'd0,   1'b0, 1'b1);
        item(0, 24'h000001, 8'd23,  24'h800000, 8'd0,   1'b0, 1'b0);
        item(0, 24'h812345, 8'd200, 24'h812345, 8'd200, 1'b0, 1'b0);
        item(0, 24'h000003, 8'd255, 24'hC00000, 8'd233, 1'b0, 1'b0);
        drain("drain_corner", 40);

        // ---------------- fairness: both valid, pointer sits at 1 ----------------
        for (int k = 0; k < 4; k++) begin
            item(1, 24'h000003 << k,       8'd60, 24'hC00000, 8'(38 + k), 1'b0, 1'b0);
            item(0, 24'h000001 << (k + 4), 8'd60, 24'h800000, 8'(41 + k), 1'b0, 1'b0);
        end
        c = 0;
        while (!bus.rsp_vld && c < 10) begin
            @(negedge clk);
            c++;
        end
        for (int k = 0; k < 8; k++) begin
            chk("throughput_vld", 64'(bus.rsp_vld), 64'd1);
            @(negedge clk);
        end
        drain("drain_fair", 40);

        // requester 1 alone gets consecutive grants
        for (int k = 0; k < 3; k++)
            item(1, 24'h000800 << k, 8'd20, 24'h800000, 8'(8 + k), 1'b0, 1'b0);
        drain("drain_req1", 40);

        // ---------------- backpressure ----------------
        @(posedge clk);
        #1 bus.rsp_rdy = 1'b0;
        for (int k = 0; k < 4; k++)
            item(0, 24'h005000 << k, 8'd30, 24'hA00000, 8'(21 + k), 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("bp_req_rdy", 64'(bus.req_rdy), 64'd0);
        chk("bp_accepts", 64'(lane_q[0].size()), 64'd2);
        @(posedge clk);
        #1 bus.rsp_rdy = 1'b1;
        drain("drain_bp", 40);

        // ---------------- reset mid-flight ----------------
        @(posedge clk);
        #1 bus.rsp_rdy = 1'b0;
        for (int k = 0; k < 3; k++)
            item(0, 24'h000080, 8'd100, 24'h800000, 8'd84, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("mid_full_req_rdy", 64'(bus.req_rdy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        lane_q[0].delete();
        lane_q[1].delete();
        bus.rsp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
`ifdef MANTISA_NORM_STATS_EN
        chk("mid_rst_stat_zero", 64'(stat_zero_cnt), 64'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        item(0, 24'h000000, 8'd5, 24'h000000, 8'd0, 1'b1, 1'b0);
        item(1, 24'h000000, 8'd9, 24'h000000, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ptr_after_rst", 64'(bus.req_rdy), 64'b01);
        drain("drain_after_rst", 30);
`ifdef MANTISA_NORM_STATS_EN
        @(negedge clk);
        chk("stat_zero_cnt", 64'(stat_zero_cnt), 64'd2);
        chk("stat_unf_cnt",  64'(stat_unf_cnt),  64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
